// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: decodes one instruction per handshake
// into {sign-extended immediate, format code, PC-relative target} behind a 2-entry buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INS,
  input  logic [XLEN-1:0]  PC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  IMM_OUT,
  output logic [2:0]       IMM_FMT,
  output logic [XLEN-1:0]  TARGET,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] ILL_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] tgt;
  } entry_t;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]      dec_fmt_s;
  logic [31:0]     imm32_s;
  logic            pc_rel_s;
  logic [XLEN-1:0] dec_imm_s;
  entry_t          new_entry_s;
  logic            push_s;
  logic            pop_s;

  // Instruction decode: 32-bit signed immediate, format code and whether TARGET is PC+IMM
  always_comb begin
    dec_fmt_s = FMT_ILL;
    imm32_s   = 32'd0;
    pc_rel_s  = 1'b0;
    case (INS[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt_s = FMT_I;
        imm32_s   = {{20{INS[31]}}, INS[31:20]};
      end
      7'b0100011: begin
        dec_fmt_s = FMT_S;
        imm32_s   = {{20{INS[31]}}, INS[31:25], INS[11:7]};
      end
      7'b1100011: begin
        dec_fmt_s = FMT_B;
        imm32_s   = {{19{INS[31]}}, INS[31], INS[7], INS[30:25], INS[11:8], 1'b0};
        pc_rel_s  = 1'b1;
      end
      7'b0110111: begin
        dec_fmt_s = FMT_U;
        imm32_s   = {INS[31:12], 12'd0};
      end
      7'b0010111: begin
        // AUIPC is the only U-type whose target is PC-relative
        dec_fmt_s = FMT_U;
        imm32_s   = {INS[31:12], 12'd0};
        pc_rel_s  = 1'b1;
      end
      7'b1101111: begin
        dec_fmt_s = FMT_J;
        imm32_s   = {{11{INS[31]}}, INS[31], INS[19:12], INS[20], INS[30:21], 1'b0};
        pc_rel_s  = 1'b1;
      end
      7'b0110011: begin
        dec_fmt_s = FMT_R;
      end
      default: begin
        dec_fmt_s = FMT_ILL;
      end
    endcase
  end

  assign dec_imm_s       = XLEN'($signed(imm32_s));
  assign new_entry_s.imm = dec_imm_s;
  assign new_entry_s.fmt = dec_fmt_s;
  assign new_entry_s.tgt = PC + (pc_rel_s ? dec_imm_s : XLEN'(32'd4));

  assign IN_READY  = (state_q != ST_FULL);
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign push_s    = IN_VALID & IN_READY;
  assign pop_s     = OUT_VALID & OUT_READY;

  // Buffer next-state: head is always the oldest entry, tail only used when full
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          head_d  = new_entry_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          head_d = new_entry_s;
        end else if (push_s) begin
          tail_d  = new_entry_s;
          state_d = ST_FULL;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Illegal-opcode counter: clear has priority, increment saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (push_s && (dec_fmt_s == FMT_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, buffer and counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IMM_OUT = head_q.imm;
  assign IMM_FMT = head_q.fmt;
  assign TARGET  = head_q.tgt;
  assign ILL_CNT = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/CNT_W=16 instance and an XLEN=64/CNT_W=2 instance,
// both checked against an arithmetic reference model and queue-based scoreboards.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [31:0] a_ins, a_pc, a_imm, a_tgt;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
  logic [31:0] b_ins;
  logic [63:0] b_pc, b_imm, b_tgt;
  logic [2:0]  b_fmt;
  logic [1:0]  b_cnt;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_a (
    .CLK(clk), .RESET(rst), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .INS(a_ins), .PC(a_pc), .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready),
    .IMM_OUT(a_imm), .IMM_FMT(a_fmt), .TARGET(a_tgt), .CNT_CLR(a_cnt_clr), .ILL_CNT(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_b (
    .CLK(clk), .RESET(rst), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .INS(b_ins), .PC(b_pc), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready),
    .IMM_OUT(b_imm), .IMM_FMT(b_fmt), .TARGET(b_tgt), .CNT_CLR(b_cnt_clr), .ILL_CNT(b_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  int unsigned ca, cb;
  int          n_assert = 0;
  int          n_fail   = 0;
  bit          pa, pb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: immediates assembled as signed sums of weighted instruction fields.
  function automatic ent_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input int xlen);
    ent_t        e;
    longint      v;
    longint      sw;
    logic [63:0] mask;
    bit          rel;
    sw   = longint'($signed(w));
    v    = 64'sd0;
    rel  = 1'b0;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; v = sw >>> 20; end
      7'h23: begin e.fmt = 3'd2; v = (sw >>> 25) * 64'sd32 + longint'(w[11:7]); end
      7'h63: begin
        e.fmt = 3'd3; rel = 1'b1;
        v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 64'sd2048
          + longint'(w[30:25]) * 64'sd32 + longint'(w[11:8]) * 64'sd2;
      end
      7'h37: begin e.fmt = 3'd4; v = (sw >>> 12) * 64'sd4096; end
      7'h17: begin e.fmt = 3'd4; v = (sw >>> 12) * 64'sd4096; rel = 1'b1; end
      7'h6F: begin
        e.fmt = 3'd5; rel = 1'b1;
        v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 64'sd4096
          + longint'(w[20]) * 64'sd2048 + longint'(w[30:21]) * 64'sd2;
      end
      7'h33: begin e.fmt = 3'd0; end
      default: begin e.fmt = 3'd7; end
    endcase
    e.imm = v & mask;
    e.tgt = (pc + (rel ? v : 64'sd4)) & mask;
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h13;
      1: w[6:0] = 7'h03;
      2: w[6:0] = 7'h67;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h33;
      default: ;
    endcase
    return w;
  endfunction

  // Advance one clock on both instances, update the scoreboards, check all outputs.
  task automatic step(output bit a_push, output bit b_push);
    ent_t ea, eb;
    bit   a_pop, b_pop;
    a_push = a_in_valid && (qa.size() < 2);
    a_pop  = (qa.size() > 0) && a_out_ready;
    b_push = b_in_valid && (qb.size() < 2);
    b_pop  = (qb.size() > 0) && b_out_ready;
    ea = ref_decode(a_ins, {32'd0, a_pc}, 32);
    eb = ref_decode(b_ins, b_pc, 64);
    @(posedge clk);
    #1;
    if (a_pop) void'(qa.pop_front());
    if (a_push) qa.push_back(ea);
    if (b_pop) void'(qb.pop_front());
    if (b_push) qb.push_back(eb);
    if (a_cnt_clr) ca = 0;
    else if (a_push && ea.fmt == 3'd7 && ca < 65535) ca++;
    if (b_cnt_clr) cb = 0;
    else if (b_push && eb.fmt == 3'd7 && cb < 3) cb++;
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("a_ill_cnt", a_cnt, ca);
    if (qa.size() > 0) begin
      chk("a_imm", a_imm, qa[0].imm);
      chk("a_fmt", a_fmt, qa[0].fmt);
      chk("a_target", a_tgt, qa[0].tgt);
    end
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    chk("b_in_ready", b_in_ready, qb.size() < 2);
    chk("b_ill_cnt", b_cnt, cb);
    if (qb.size() > 0) begin
      chk("b_imm", b_imm, qb[0].imm);
      chk("b_fmt", b_fmt, qb[0].fmt);
      chk("b_target", b_tgt, qb[0].tgt);
    end
  endtask

  // Present one instruction and clock until it is accepted (bounded).
  task automatic push_one(input bit to_b, input logic [31:0] w, input logic [63:0] p);
    bit done;
    done = 1'b0;
    if (to_b) begin b_in_valid = 1'b1; b_ins = w; b_pc = p; end
    else begin a_in_valid = 1'b1; a_ins = w; a_pc = p[31:0]; end
    for (int i = 0; i < 8 && !done; i++) begin
      step(pa, pb);
      done = to_b ? pb : pa;
    end
    chk(to_b ? "b_push_accept" : "a_push_accept", done, 1'b1);
    if (to_b) b_in_valid = 1'b0;
    else a_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_a_imm", a_imm, 32'd0);
    chk("rst_a_fmt", a_fmt, 3'd0);
    chk("rst_a_target", a_tgt, 32'd0);
    chk("rst_a_cnt", a_cnt, 16'd0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    chk("rst_b_cnt", b_cnt, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_cnt_clr = 1'b0; a_ins = 32'd0; a_pc = 32'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_cnt_clr = 1'b0; b_ins = 32'd0; b_pc = 64'd0;
    ca = 0; cb = 0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // addi x1, x0, -1 at PC 0x100
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    push_one(1'b0, 32'hFFF0_0093, 64'h100);
    chk("addi_imm", a_imm, 32'hFFFF_FFFF);
    chk("addi_fmt", a_fmt, 3'd1);
    chk("addi_target", a_tgt, 32'h0000_0104);

    // sw then beq +8 back to back with the consumer ready
    push_one(1'b0, 32'hFE20_AE23, 64'h200);
    chk("sw_imm", a_imm, 32'hFFFF_FFFC);
    chk("sw_fmt", a_fmt, 3'd2);
    push_one(1'b0, 32'h0000_0463, 64'h100);
    chk("beq_imm", a_imm, 32'h0000_0008);
    chk("beq_fmt", a_fmt, 3'd3);
    chk("beq_target", a_tgt, 32'h0000_0108);

    // jal -4 at PC 0 wraps the target
    push_one(1'b0, 32'hFFDF_F0EF, 64'h0);
    chk("jal_imm", a_imm, 32'hFFFF_FFFC);
    chk("jal_fmt", a_fmt, 3'd5);
    chk("jal_target", a_tgt, 32'hFFFF_FFFC);

    // RV64 lui sign-extends bit 31
    push_one(1'b1, 32'h8000_02B7, 64'h1000);
    chk("lui64_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_fmt", b_fmt, 3'd4);
    chk("lui64_target", b_tgt, 64'h0000_0000_0000_1004);
    step(pa, pb);

    // Backpressure: two pushes fill the buffer, the third waits
    a_out_ready = 1'b0;
    push_one(1'b0, 32'h0010_0113, 64'h300);
    push_one(1'b0, 32'h0041_2183, 64'h304);
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    a_in_valid = 1'b1; a_ins = 32'h0000_0517; a_pc = 32'h308;
    step(pa, pb);
    chk("bp_third_blocked", pa, 1'b0);
    step(pa, pb);
    chk("bp_head_auipc_not_yet", a_imm, 32'd1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 6 && !pa; i++) step(pa, pb);
    chk("bp_third_accepted", pa, 1'b1);
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(pa, pb);
    chk("bp_drained", a_out_valid, 1'b0);

    // Illegal opcodes, then clear racing a fourth illegal push
    for (int i = 0; i < 3; i++) push_one(1'b0, 32'h0000_007F, 64'h400 + 64'(4 * i));
    chk("ill_cnt3", a_cnt, 16'd3);
    chk("ill_fmt", a_fmt, 3'd7);
    chk("ill_imm", a_imm, 32'd0);
    a_cnt_clr = 1'b1;
    push_one(1'b0, 32'h0000_007F, 64'h40C);
    a_cnt_clr = 1'b0;
    chk("ill_clr_wins", a_cnt, 16'd0);
    step(pa, pb);
    chk("ill_no_clear_on_pop", a_cnt, 16'd0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) push_one(1'b1, 32'hFFFF_FFFF, 64'h800);
    chk("sat_cnt", b_cnt, 2'd3);

    // Randomised traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_cnt_clr   = ($urandom_range(0, 31) == 0);
      a_ins       = rand_ins();
      a_pc        = $urandom();
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_cnt_clr   = ($urandom_range(0, 31) == 0);
      b_ins       = rand_ins();
      b_pc        = {$urandom(), $urandom()};
      step(pa, pb);
    end
    a_cnt_clr = 1'b0;
    b_cnt_clr = 1'b0;

    // Fill buffers, then assert reset between edges
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_valid = 1'b1; b_in_valid = 1'b1;
    a_ins = 32'h0000_007F; b_ins = 32'h0000_007F;
    for (int i = 0; i < 4 && (qa.size() < 2 || qb.size() < 2); i++) step(pa, pb);
    chk("full_before_reset", a_in_ready, 1'b0);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    qa.delete(); qb.delete(); ca = 0; cb = 0;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    step(pa, pb);
    push_one(1'b0, 32'h0000_0413, 64'h500);
    step(pa, pb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
